// File: rtl/skid_pipe_pkg.sv
// skid_pipe_pkg: shared types and constants for the skid_pipe elastic stage.
//   state_t  : pipeline occupancy state; the 2-bit encoding equals the number
//              of entries held, so the state register doubles as the level.
//   LEVEL_W  : width of the level output.
package skid_pipe_pkg;

  localparam int LEVEL_W = 2;

  typedef enum logic [LEVEL_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/up_cnt_wrap.sv
// up_cnt_wrap: generic wrapping up-counter.
//   sys_clk : clock, rising edge
//   sys_rst : synchronous active-high reset, clears the count to 0
//   en      : increment enable; the count wraps from 2^CNT_W-1 to 0
//   cnt     : current count
module up_cnt_wrap #(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/skid_pipe.sv
// skid_pipe: two-entry elastic pipeline stage with valid/ready on both sides.
//   sys_clk   : clock, rising edge
//   sys_rst   : synchronous active-high reset
//   in_data   : upstream data            in_valid  : upstream data valid
//   in_ready  : stage can take a beat (decoded from the state register only)
//   out_data  : downstream data (main register)
//   out_valid : out_data holds a beat    out_ready : downstream takes the beat
//   level     : entries held (0..2); equals the state encoding, so it also
//               serves as the observable FSM state
//   beat_cnt  : wrapping count of accepted input beats
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on that side (push = in_valid & in_ready, pop = out_valid & out_ready). A
// held beat keeps out_data/out_valid stable until popped; in_valid may drop
// at any time. in_ready depends only on state, so the upstream ready path is
// cut: when the consumer stalls, the second beat lands in the skid register.
module skid_pipe
  import skid_pipe_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   beat_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   r_skid;
  logic               w_push;
  logic               w_pop;
  logic               w_in_ready;
  logic               w_out_valid;
  logic [LEVEL_W-1:0] w_level;

  assign w_push = in_valid & w_in_ready;
  assign w_pop  = w_out_valid & out_ready;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the unused encoding falls back to EMPTY
  always_comb begin
    w_state_nxt = ST_EMPTY;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_push ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
        else                       w_state_nxt = ST_ONE;
      end
      ST_FULL:  w_state_nxt = w_pop ? ST_ONE : ST_FULL;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output decode. The unused encoding reports nothing held and refuses
  // input so no beat is taken during the one-cycle recovery.
  always_comb begin
    w_level     = '0;
    w_out_valid = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_level     = 2'd0;
        w_out_valid = 1'b0;
        w_in_ready  = 1'b1;
      end
      ST_ONE: begin
        w_level     = 2'd1;
        w_out_valid = 1'b1;
        w_in_ready  = 1'b1;
      end
      ST_FULL: begin
        w_level     = 2'd2;
        w_out_valid = 1'b1;
        w_in_ready  = 1'b0;
      end
      default: begin
        w_level     = '0;
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
      end
    endcase
  end

  // Data path: main feeds the output, skid catches the beat that arrives
  // while the consumer is stalling a single held beat.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) r_main <= in_data;
        end
        ST_ONE: begin
          if (w_push && w_pop) r_main <= in_data;
          else if (w_push)     r_skid <= in_data;
        end
        ST_FULL: begin
          if (w_pop) r_main <= r_skid;
        end
        default: ;
      endcase
    end
  end

  up_cnt_wrap #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (w_push),
    .cnt     (beat_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign level     = w_level;
  assign out_data  = r_main;

endmodule

// File: tb/tb_skid_pipe.sv
module tb_skid_pipe;

  // ---------------- clock / reset ----------------
  logic sys_clk;
  logic sys_rst;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ---------------- DUT A: WIDTH=8, CNT_W=8 ----------------
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] level;
  logic [7:0] beat_cnt;

  skid_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .beat_cnt  (beat_cnt)
  );

  // ---------------- DUT B: WIDTH=2, CNT_W=2 (counter wrap) ----------------
  logic [1:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [1:0] b_out_data;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [1:0] b_level;
  logic [1:0] b_beat_cnt;

  skid_pipe #(.WIDTH(2), .CNT_W(2)) u_dut_b (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .level     (b_level),
    .beat_cnt  (b_beat_cnt)
  );

  // ---------------- counters / check ----------------
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // ---------------- scoreboard (DUT A) ----------------
  // At each falling edge: first compare DUT state with the model built from
  // all completed edges, then record the handshakes the next rising edge
  // will perform (inputs are stable since #1 after the previous edge).
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt   = '0;
  logic       mon_en    = 1'b0;
  logic       hold_vld  = 1'b0;
  logic [7:0] hold_data = '0;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      check("level",     32'(level),     exp_q.size());
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
      check("beat_cnt",  32'(beat_cnt),  32'(exp_cnt));
      if (hold_vld) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  32'(out_data),  32'(hold_data));
      end
    end
    hold_vld = 1'b0;
    if (sys_rst) begin
      exp_q.delete();
      exp_cnt = '0;
      mon_en  = 1'b1;
    end else if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_underflow", exp_q.size(), 32'd1);
        else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (out_valid && !out_ready) begin
        hold_vld  = 1'b1;
        hold_data = out_data;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [1:0] cnt_seq [5];

  initial begin
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sys_rst     = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    cycles(2);
    sys_rst = 1'b0;

    // Reset state
    check("rst_level",     32'(level),      32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_data",  32'(out_data),   32'd0);
    check("rst_beat_cnt",  32'(beat_cnt),   32'd0);
    check("rst_b_cnt",     32'(b_beat_cnt), 32'd0);

    // Single beat through an empty stage
    in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
    cyc();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data",  32'(out_data),  32'h01);
    check("t1_level",     32'(level),     32'd1);
    check("t1_beat_cnt",  32'(beat_cnt),  32'd1);
    in_valid = 1'b0;
    cyc();
    check("t1_level_drain", 32'(level), 32'd0);

    // Fill to FULL under a stall, then release
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h02;
    cyc();
    in_data = 8'h03;
    cyc();
    in_valid = 1'b0;
    check("t2_level",    32'(level),    32'd2);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_out_data", 32'(out_data), 32'h02);
    out_ready = 1'b1;
    cyc();
    check("t2_in_ready_back", 32'(in_ready), 32'd1);
    check("t2_out_data2",     32'(out_data), 32'h03);
    check("t2_level1",        32'(level),    32'd1);
    cyc();
    check("t2_level0", 32'(level), 32'd0);

    // Streaming: one beat per cycle, one cycle delay
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i % 4);
      cyc();
      check("t3_out_data", 32'(out_data), 32'(i % 4));
      check("t3_level",    32'(level),    32'd1);
    end
    in_valid = 1'b0;
    cyc();

    // Random traffic, 50% valid / 50% ready
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycles(3);
    check("t4_drain_q", exp_q.size(), 32'd0);

    // Reset while FULL with push and pop both requested
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h02;
    cyc();
    in_data = 8'h03;
    cyc();
    check("t5_full", 32'(level), 32'd2);
    sys_rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    cyc();
    sys_rst = 1'b0; in_valid = 1'b0;
    check("t5_level",     32'(level),     32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    check("t5_out_data",  32'(out_data),  32'd0);
    check("t5_beat_cnt",  32'(beat_cnt),  32'd0);
    cycles(2);
    check("t5_no_emit", 32'(out_valid), 32'd0);

    // Counter wrap with CNT_W=2
    b_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_data = 2'(i);
      cyc();
      check("t6_b_beat_cnt", 32'(b_beat_cnt), 32'(cnt_seq[i]));
    end
    b_in_valid = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/skid_pipe.md
Name: skid_pipe

Overview:
- Two-entry elastic pipeline stage with valid/ready handshakes on both sides.
- Carries a WIDTH-bit stream forward, like the team's fixed two-register delay pipes, and also propagates backpressure upstream.
- Sits between a producer and a consumer that may stall.
- Breaks the ready path combinationally: in_ready is a register output.

Parameters:
- WIDTH, 2, data bus width in bits.
- CNT_W, 8, width of the accepted-beat counter; wraps modulo 2^CNT_W.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept a beat; registered.
- out_data  output  WIDTH  downstream data; registered.
- out_valid  output  1  out_data holds a valid beat; registered.
- out_ready  input  1  downstream accepts the beat.
- level  output  2  entries held (0, 1 or 2); registered.
- beat_cnt  output  CNT_W  count of accepted input beats.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high; it is sampled only on the rising edge of sys_clk.
- push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the same rising edge.
- Storage: main register (drives out_data) and skid register.
- States:
  - EMPTY: level 0, out_valid 0, in_ready 1.
  - ONE: level 1, out_valid 1, in_ready 1.
  - FULL: level 2, out_valid 1, in_ready 0.
- Transitions:
  - EMPTY, push -> ONE; main<=in_data.
  - EMPTY, no push -> EMPTY; in_valid while empty is simply accepted next edge, nothing is lost.
  - ONE, push & pop -> ONE; main<=in_data.
  - ONE, push & !pop -> FULL; skid<=in_data.
  - ONE, pop & !push -> EMPTY.
  - ONE, neither -> ONE, hold.
  - FULL, pop -> ONE; main<=skid. No push is possible because in_ready=0.
  - FULL, !pop -> FULL, hold.
- Latency:
  - A beat accepted at edge k is on out_data with out_valid=1 from edge k onward when the block was EMPTY.
  - Otherwise it is presented in strict FIFO order behind the older beats.
  - No beat is ever dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Deassertion: out_valid falls only after a pop. Upstream may drop in_valid at any time; the block imposes no rule on it.
- In EMPTY, out_data keeps its last value, and consumers must ignore it.
- beat_cnt increments by 1 on every push and wraps from 2^CNT_W-1 to 0.
- level, in_ready and out_valid are direct decodes of registered state; no combinational input-to-output paths.
- Reset (sys_rst=1 at an edge), applied from any state including FULL mid-transfer:
  - state EMPTY, level 0, out_valid 0, in_ready 1, out_data 0, skid 0, beat_cnt 0.
  - Held contents are discarded.
  - A push or pop coinciding with reset is ignored.
- Illegal state encodings recover to EMPTY at the next edge.

Decomposition:
- Shared package: state enum for EMPTY/ONE/FULL, with 2-bit encodings equal to level (0/1/2), and the LEVEL_W=2 constant.
- No sub-module required. The beat counter may be a separate generic wrapping-counter module, up_cnt_wrap, with parameter CNT_W and inputs en/sys_rst.

Test Plan:
- Reset then in_valid=1, in_data=2'b01 for one cycle with out_ready=1 -> out_valid=1, out_data=01 after that edge; level=1; beat_cnt=1; next edge level=0.
- out_ready=0, push 2'b10 then 2'b11 on consecutive edges -> level=2, in_ready=0, out_data=10. Set out_ready=1 -> outputs 10 then 11, in_ready returns 1 after the first pop.
- Continuous in_valid=1 and out_ready=1 with data 0,1,2,3 repeating -> throughput one beat per cycle; out_data equals in_data delayed one cycle; level stays 1.
- Random in_valid/out_ready at 50% each, 1000 cycles, WIDTH=8 -> output sequence equals input sequence (scoreboard). out_data stable whenever out_valid & !out_ready. level never exceeds 2.
- Fill to FULL with 2'b10 and 2'b11, then assert sys_rst for one cycle with out_ready=1 and in_valid=1 -> after that edge level=0, out_valid=0, in_ready=1, out_data=0, beat_cnt=0; no beat emitted.
- CNT_W=2: accept 5 beats -> beat_cnt sequence 1,2,3,0,1.
